// File: rtl/hififo_fpc_reorder.sv
// Completion reorder buffer: tags reads, stores completions per slot and releases qwords in request order.
// Latency: accepted qword at the read pointer -> out_valid two cycles later; out path stalls on out_ready, rc path never stalls.

module hififo_fpc_reorder_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (clear) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= ptr_next(wp);
      if (pop)  rp <= ptr_next(rp);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wp] <= push_data;
  end

  assign head_data = mem[rp];
  assign empty     = (count == '0);
endmodule

module hififo_fpc_reorder #(
  parameter int SLOT_BITS = 3,
  parameter int WORD_BITS = 6
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic [1:0]           fifo_number,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  output logic [SLOT_BITS-1:0] alloc_tag,
  input  logic                 rc_valid,
  input  logic [7:0]           rc_tag,
  input  logic [WORD_BITS-1:0] rc_index,
  input  logic [63:0]          rc_data,
  output logic                 out_valid,
  output logic [63:0]          out_data,
  input  logic                 out_ready,
  output logic [SLOT_BITS:0]   inflight,
  output logic                 error
);
  localparam int SLOTS     = 1 << SLOT_BITS;
  localparam int CNT_BITS  = WORD_BITS + 1;
  localparam int INF_BITS  = SLOT_BITS + 1;
  localparam int ADDR_BITS = SLOT_BITS + WORD_BITS;

  logic [SLOT_BITS-1:0] wr_slot, rd_slot;
  logic [WORD_BITS-1:0] rd_idx;
  logic [CNT_BITS-1:0]  rcv_count [SLOTS];
  logic [INF_BITS-1:0]  inflight_q;
  logic                 error_q;
  logic                 rd_pend;

  logic                 alloc_fire, rd_fire, free_fire;
  logic [SLOT_BITS-1:0] rc_slot, rc_off;
  logic                 rc_mine, rc_alloc, rc_accept, rc_bad;
  logic [2:0]           stage_occ;

  logic [63:0]          mem [1 << ADDR_BITS];
  logic [63:0]          ram_q;

  logic                 stage_push, stage_pop, stage_empty;
  logic [63:0]          stage_head;
  logic [1:0]           stage_count;

  assign inflight  = inflight_q;
  assign error     = error_q;
  assign alloc_tag = wr_slot;

  always_comb begin
    alloc_ready = (inflight_q != INF_BITS'(SLOTS));
    alloc_fire  = alloc_valid && alloc_ready;

    // Reads already in the RAM pipeline count against the 2-entry output stage.
    stage_occ = 3'(stage_count) + 3'(rd_pend);
    rd_fire   = (inflight_q != '0) &&
                (rcv_count[rd_slot] > {1'b0, rd_idx}) &&
                (stage_occ < 3'd2);
    free_fire = rd_fire && (rd_idx == '1);

    rc_slot   = rc_tag[SLOT_BITS-1:0];
    rc_off    = rc_slot - rd_slot;
    rc_alloc  = ({1'b0, rc_off} < inflight_q) && !(free_fire && (rc_slot == rd_slot));
    rc_mine   = rc_valid && (rc_tag[SLOT_BITS+1:SLOT_BITS] == fifo_number);
    rc_accept = rc_mine && (rc_tag[7:SLOT_BITS+2] == '0) && rc_alloc &&
                ({1'b0, rc_index} == rcv_count[rc_slot]);
    rc_bad    = rc_mine && !rc_accept;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_slot    <= '0;
      rd_slot    <= '0;
      rd_idx     <= '0;
      inflight_q <= '0;
      error_q    <= 1'b0;
      rd_pend    <= 1'b0;
      for (int s = 0; s < SLOTS; s++) rcv_count[s] <= '0;
    end else if (flush) begin
      wr_slot    <= '0;
      rd_slot    <= '0;
      rd_idx     <= '0;
      inflight_q <= '0;
      error_q    <= 1'b0;
      rd_pend    <= 1'b0;
      for (int s = 0; s < SLOTS; s++) rcv_count[s] <= '0;
    end else begin
      if (alloc_fire) wr_slot <= wr_slot + SLOT_BITS'(1);
      if (alloc_fire && !free_fire)      inflight_q <= inflight_q + INF_BITS'(1);
      else if (free_fire && !alloc_fire) inflight_q <= inflight_q - INF_BITS'(1);
      if (rd_fire)   rd_idx  <= rd_idx + WORD_BITS'(1);
      if (free_fire) rd_slot <= rd_slot + SLOT_BITS'(1);
      for (int s = 0; s < SLOTS; s++) begin
        if (free_fire && (rd_slot == SLOT_BITS'(s)))
          rcv_count[s] <= '0;
        else if (rc_accept && (rc_slot == SLOT_BITS'(s)))
          rcv_count[s] <= rcv_count[s] + CNT_BITS'(1);
      end
      rd_pend <= rd_fire;
      if (rc_bad) error_q <= 1'b1;
    end
  end

  // Write and read never collide: the read index is always below the slot's receive count.
  always_ff @(posedge clock) begin
    if (rc_accept) mem[{rc_slot, rc_index}] <= rc_data;
    if (rd_fire)   ram_q <= mem[{rd_slot, rd_idx}];
  end

  // RAM output bypasses the stage when it is empty and the sink is ready.
  always_comb begin
    out_valid  = !stage_empty || rd_pend;
    out_data   = stage_empty ? ram_q : stage_head;
    stage_pop  = out_ready && !stage_empty;
    stage_push = rd_pend && !(stage_empty && out_ready);
  end

  hififo_fpc_reorder_fifo #(.W(64), .DEPTH(2)) u_out_stage (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (flush),
    .push      (stage_push),
    .push_data (ram_q),
    .pop       (stage_pop),
    .head_data (stage_head),
    .empty     (stage_empty),
    .count     (stage_count)
  );
endmodule
